// File: rtl/mem_arbiter_if.sv
// Bundle of requester and Memory-side signals for mem_arbiter.
// slave = the arbiter itself; master = requesters plus Memory.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_load_bar;
  logic        mem_drive;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        rom_wr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_addr, mem_en, mem_load_bar, mem_drive, mem_wdata, rom_wr_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_addr, mem_en, mem_load_bar, mem_drive, mem_wdata, rom_wr_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported Memory between CPU and DMA,
// sequencing IDLE -> ACCESS -> DONE and dropping writes aimed at the ROM region.
module mem_arbiter #(
  parameter int ROM_TOP     = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset_bar,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt_dma;
  logic        r_last_dma;
  logic        r_we;
  logic        r_err;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_dma_rdata;
  logic [2:0]  r_cnt;

  logic        w_any;
  logic        w_pick_dma;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic        w_last_beat;

  // On a tie the requester that was not served last wins.
  assign w_any       = bus.cpu_req | bus.dma_req;
  assign w_pick_dma  = bus.dma_req & (~bus.cpu_req | ~r_last_dma);
  assign w_sel_we    = w_pick_dma ? bus.dma_we    : bus.cpu_we;
  assign w_sel_addr  = w_pick_dma ? bus.dma_addr  : bus.cpu_addr;
  assign w_sel_wdata = w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign w_last_beat = (r_cnt == 3'(WAIT_STATES));

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  if (w_last_beat) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_gnt_dma   <= 1'b0;
      r_last_dma  <= 1'b1;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_gnt_dma  <= w_pick_dma;
        r_last_dma <= w_pick_dma;
        r_we       <= w_sel_we;
        r_err      <= w_sel_we & ({1'b0, w_sel_addr} < 17'(ROM_TOP));
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
      end
      if (r_state == ACCESS) begin
        r_cnt <= w_last_beat ? 3'd0 : r_cnt + 3'd1;
        // Read data is captured only on the closing edge of the access window.
        if (w_last_beat && !r_we) begin
          if (r_gnt_dma) r_dma_rdata <= bus.mem_rdata;
          else           r_cpu_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  always_comb begin
    bus.mem_en       = 1'b0;
    bus.mem_drive    = 1'b0;
    bus.mem_load_bar = 1'b1;
    bus.cpu_ack      = 1'b0;
    bus.dma_ack      = 1'b0;
    bus.rom_wr_err   = 1'b0;
    case (r_state)
      ACCESS: begin
        bus.mem_en       = ~r_we;
        bus.mem_drive    = r_we & ~r_err;
        bus.mem_load_bar = ~(r_we & ~r_err);
      end
      DONE: begin
        bus.cpu_ack    = ~r_gnt_dma;
        bus.dma_ack    = r_gnt_dma;
        bus.rom_wr_err = r_err;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a memory-level reference model predicts
// every ack's read data and error flag; a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int ROM_TOP = 256;

  logic clk = 1'b0;
  logic reset_bar = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ack_cnt = 0;
  int   lb_low_cnt = 0;
  int   en1_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus0();
  mem_arbiter_if bus1();

  mem_arbiter #(.ROM_TOP(ROM_TOP), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset_bar(reset_bar), .bus(bus0.slave));
  mem_arbiter #(.ROM_TOP(ROM_TOP), .WAIT_STATES(2)) u1 (
    .clk(clk), .reset_bar(reset_bar), .bus(bus1.slave));

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  // Memory block: writes whatever is strobed, so a leaked ROM write corrupts it.
  logic [15:0] mem [0:65535];
  assign bus0.mem_rdata = bus0.mem_en ? mem[bus0.mem_addr] : 16'h0000;
  assign bus1.mem_rdata = bus1.mem_en ? mem[bus1.mem_addr] : 16'h0000;
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = init_val(16'(a));
    forever begin
      @(posedge clk);
      if (!bus0.mem_load_bar) mem[bus0.mem_addr] <= bus0.mem_wdata;
    end
  end

  // Reference model: what each location should hold and what each ack should report.
  typedef struct {
    bit          rd;
    logic [15:0] data;
    bit          err;
  } exp_t;
  logic [15:0] ref_mem [0:65535];
  exp_t q_cpu[$];
  exp_t q_dma[$];

  task automatic model(input int who, input bit we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.rd   = !we;
    e.err  = we && (a < ROM_TOP);
    e.data = ref_mem[a];
    if (we && a >= ROM_TOP) ref_mem[a] = d;
    if (who == 0) q_cpu.push_back(e);
    else          q_dma.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ack(input int who, input logic [15:0] rd, input logic err);
    exp_t e;
    string nm;
    nm = (who == 0) ? "cpu" : "dma";
    checks++;
    if ((who == 0 && q_cpu.size() == 0) || (who == 1 && q_dma.size() == 0)) begin
      errors++;
      $display("FAIL %s_ack_unexpected: got an ack, expected none", nm);
      return;
    end
    if (who == 0) e = q_cpu.pop_front();
    else          e = q_dma.pop_front();
    if ((e.rd && rd !== e.data) || err !== e.err) begin
      errors++;
      $display("FAIL %s_ack_resp: got rdata=%h err=%b, expected rdata=%h err=%b (read=%b)",
               nm, rd, err, e.data, e.err, e.rd);
    end
  endtask

  // Monitor: scoreboard pops plus bus-level invariants, sampled mid-cycle.
  initial begin
    logic [15:0] prev_c, prev_d;
    prev_c = 16'h0;
    prev_d = 16'h0;
    forever begin
      @(negedge clk);
      if (reset_bar) begin
        if (!bus0.mem_load_bar) lb_low_cnt++;
        if (bus1.mem_en) en1_cnt++;
        if (bus0.cpu_ack || bus0.dma_ack) ack_cnt++;
        checks++;
        if ((bus0.mem_en && bus0.mem_drive) || (bus0.cpu_ack && bus0.dma_ack) ||
            ((!bus0.mem_load_bar || bus0.mem_drive) && bus0.mem_addr < ROM_TOP) ||
            (bus0.rom_wr_err && !bus0.cpu_ack && !bus0.dma_ack) ||
            (bus0.cpu_rdata !== prev_c && !bus0.cpu_ack) ||
            (bus0.dma_rdata !== prev_d && !bus0.dma_ack)) begin
          errors++;
          $display("FAIL bus_invariant: got en=%b drive=%b load_bar=%b addr=%h acks=%b%b err=%b rdata=%h/%h, expected exclusive bus, no ROM strobe, rdata change only with own ack",
                   bus0.mem_en, bus0.mem_drive, bus0.mem_load_bar, bus0.mem_addr,
                   bus0.cpu_ack, bus0.dma_ack, bus0.rom_wr_err, bus0.cpu_rdata, bus0.dma_rdata);
        end
        if (bus0.cpu_ack) check_ack(0, bus0.cpu_rdata, bus0.rom_wr_err);
        if (bus0.dma_ack) check_ack(1, bus0.dma_rdata, bus0.rom_wr_err);
      end
      prev_c = bus0.cpu_rdata;
      prev_d = bus0.dma_rdata;
    end
  end

  task automatic txn(input int who, input bit we, input logic [15:0] a, input logic [15:0] d,
                     input bit keep, output int t_req, output int t_ack);
    bit got;
    got = 0;
    t_ack = -1;
    model(who, we, a, d);
    @(negedge clk);
    if (who == 0) begin
      bus0.cpu_req = 1'b1; bus0.cpu_we = we; bus0.cpu_addr = a; bus0.cpu_wdata = d;
    end else begin
      bus0.dma_req = 1'b1; bus0.dma_we = we; bus0.dma_addr = a; bus0.dma_wdata = d;
    end
    t_req = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((who == 0 && bus0.cpu_ack) || (who == 1 && bus0.dma_ack)) begin
        got = 1;
        t_ack = cyc;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack in 40 cycles, expected an ack", who);
    end
    if (!keep) begin
      if (who == 0) bus0.cpu_req = 1'b0;
      else          bus0.dma_req = 1'b0;
    end
  endtask

  task automatic rand_stream(input int who, input int n);
    int tr, ta;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 255));
      else a = 16'((who == 0 ? 16'h0300 : 16'h0400) + $urandom_range(0, 255));
      txn(who, 1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0, tr, ta);
    end
  endtask

  initial begin
    int tc, ta_c, td, ta_d, snap;
    int c_t[4];
    int d_t[4];
    bit got;

    bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
    bus0.dma_req = 0; bus0.dma_we = 0; bus0.dma_addr = 0; bus0.dma_wdata = 0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
    bus1.dma_req = 0; bus1.dma_we = 0; bus1.dma_addr = 0; bus1.dma_wdata = 0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(16'(a));

    #12;
    chk("reset_ctrl", 32'({bus0.cpu_ack, bus0.dma_ack, bus0.rom_wr_err, bus0.mem_en,
                           bus0.mem_drive, bus0.mem_load_bar}), 32'b000001);
    chk("reset_addr_wdata", {bus0.mem_addr, bus0.mem_wdata}, 32'h0);
    chk("reset_rdata", {bus0.cpu_rdata, bus0.dma_rdata}, 32'h0);
    @(negedge clk);
    reset_bar = 1'b1;

    // Simultaneous reads straight after reset: CPU must win the first tie.
    fork
      txn(0, 1'b0, 16'h0010, 16'h0, 1'b0, tc, ta_c);
      txn(1, 1'b0, 16'h0400, 16'h0, 1'b0, td, ta_d);
    join
    chk("tie_cpu_latency", 32'(ta_c - tc), 32'd2);
    chk("tie_dma_after_cpu", 32'(ta_d - ta_c), 32'd3);
    chk("tie_dma_rdata", 32'(bus0.dma_rdata), 32'(init_val(16'h0400)));

    snap = lb_low_cnt;
    txn(0, 1'b1, 16'h0300, 16'h1234, 1'b0, tc, ta_c);
    chk("wr_latency", 32'(ta_c - tc), 32'd2);
    chk("wr_strobe_cycles", 32'(lb_low_cnt - snap), 32'd1);
    txn(0, 1'b0, 16'h0300, 16'h0, 1'b0, tc, ta_c);
    chk("rd_back_0300", 32'(bus0.cpu_rdata), 32'h1234);

    snap = lb_low_cnt;
    txn(1, 1'b1, 16'h00FF, 16'hBEEF, 1'b0, td, ta_d);
    chk("rom_wr_no_strobe", 32'(lb_low_cnt - snap), 32'd0);
    txn(1, 1'b0, 16'h00FF, 16'h0, 1'b0, td, ta_d);
    chk("rom_rd_back_00FF", 32'(bus0.dma_rdata), 32'(init_val(16'h00FF)));

    fork
      rand_stream(0, 40);
      rand_stream(1, 40);
    join

    // Both requesters hold req: service must alternate with a 6-cycle period each.
    repeat (2) @(negedge clk);
    fork
      for (int i = 0; i < 4; i++) txn(0, 1'b0, 16'h0320, 16'h0, (i < 3), tc, c_t[i]);
      for (int i = 0; i < 4; i++) txn(1, 1'b0, 16'h0420, 16'h0, (i < 3), td, d_t[i]);
    join
    for (int i = 0; i < 3; i++) begin
      chk("alt_cpu_period", 32'(c_t[i+1] - c_t[i]), 32'd6);
      chk("alt_dma_period", 32'(d_t[i+1] - d_t[i]), 32'd6);
    end
    chk("alt_offset", 32'((c_t[0] > d_t[0]) ? c_t[0] - d_t[0] : d_t[0] - c_t[0]), 32'd3);

    // Wait-state instance.
    snap = en1_cnt;
    got = 0;
    ta_c = -1;
    @(negedge clk);
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0500;
    tc = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack) begin got = 1; ta_c = cyc; break; end
    end
    bus1.cpu_req = 1'b0;
    chk("ws2_acked", 32'(got), 32'd1);
    chk("ws2_latency", 32'(ta_c - tc), 32'd4);
    chk("ws2_en_cycles", 32'(en1_cnt - snap), 32'd3);
    chk("ws2_rdata", 32'(bus1.cpu_rdata), 32'(init_val(16'h0500)));

    // Reset in the middle of a CPU write access.
    repeat (2) @(negedge clk);
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h0333; bus0.cpu_wdata = 16'hAAAA;
    @(posedge clk);
    #1;
    chk("mid_wr_strobe_low", 32'(bus0.mem_load_bar), 32'd0);
    #1;
    reset_bar = 1'b0;
    bus0.cpu_req = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({bus0.cpu_ack, bus0.mem_en, bus0.mem_drive, bus0.mem_load_bar}), 32'b0001);
    chk("rst_mid_addr_rdata", {bus0.mem_addr, bus0.cpu_rdata}, 32'h0);
    repeat (2) @(negedge clk);
    reset_bar = 1'b1;
    snap = ack_cnt;
    repeat (6) @(negedge clk);
    chk("rst_no_ack", 32'(ack_cnt - snap), 32'd0);
    fork
      txn(0, 1'b0, 16'h0302, 16'h0, 1'b0, tc, ta_c);
      txn(1, 1'b0, 16'h0402, 16'h0, 1'b0, td, ta_d);
    join
    chk("rst_cpu_wins", 32'(ta_c < ta_d), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_cpu_drained", 32'(q_cpu.size()), 32'd0);
    chk("sb_dma_drained", 32'(q_dma.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at 2ms, expected completion");
    $fatal(1, "timeout");
  end
endmodule
